// File: rtl/inst_mem_responder.sv
// Instruction-fetch memory responder: builds 32-bit words from two 16-bit ROM beats
// and keeps a held word plus a one-entry sequential prefetch for zero-wait straight-line fetch.
module inst_mem_responder #(
    parameter int XLEN        = 32,
    parameter int WAIT_STATES = 2,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_mem_read_en,
    input  logic [XLEN-1:0] inst_addr,
    output logic [XLEN-1:0] inst_data,
    output logic            inst_mem_ready,
    output logic            rom_rd,
    output logic [XLEN-1:0] rom_addr,
    input  logic [15:0]     rom_data
);

    typedef enum logic [2:0] {IDLE, D_LO, D_HI, P_LO, P_HI} state_t;

    localparam int            CW       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);
    localparam logic [XLEN-1:0] TWO    = XLEN'(2);
    localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic [XLEN-1:0] pf_addr, pf_addr_n, pf_data, pf_data_n;
    logic [XLEN-1:0] hold_addr, hold_addr_n, hold_data, hold_data_n;
    logic            hold_v, hold_v_n, pf_v, pf_v_n;
    logic [15:0]     word_lo, word_lo_n;

    logic [XLEN-1:0] addr_w;
    logic [XLEN-1:0] beat_word;
    logic            hold_match, pf_match, miss, beat_last;

    assign addr_w     = inst_addr & ~XLEN'(3);
    assign beat_word  = XLEN'({rom_data, word_lo});
    assign hold_match = hold_v && (addr_w == hold_addr);
    assign pf_match   = pf_v && (addr_w == pf_addr);
    assign miss       = inst_mem_read_en && !inst_mem_ready;
    assign beat_last  = (cnt == CNT_LAST);

    assign inst_mem_ready = hold_match || pf_match;
    assign inst_data      = (!hold_match && pf_match) ? pf_data : hold_data;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_n     = state;
        req_addr_n  = req_addr;
        pf_addr_n   = pf_addr;
        pf_data_n   = pf_data;
        pf_v_n      = pf_v;
        hold_addr_n = hold_addr;
        hold_data_n = hold_data;
        hold_v_n    = hold_v;
        word_lo_n   = word_lo;
        rom_rd      = 1'b1;
        rom_addr    = '0;

        case (state)
            IDLE: begin
                rom_rd = 1'b0;
                if (inst_mem_read_en && pf_match) begin
                    hold_addr_n = pf_addr;
                    hold_data_n = pf_data;
                    hold_v_n    = 1'b1;
                    pf_v_n      = 1'b0;
                    if (PREFETCH_EN) begin
                        pf_addr_n = pf_addr + FOUR;
                        state_n   = P_LO;
                    end
                end else if (miss) begin
                    // A miss elsewhere breaks the sequential stream, so the prefetch is dropped.
                    req_addr_n = addr_w;
                    pf_v_n     = 1'b0;
                    state_n    = D_LO;
                end
            end

            D_LO, D_HI: begin
                rom_addr = (state == D_LO) ? req_addr : req_addr + TWO;
                if (beat_last) begin
                    if (inst_mem_read_en && (addr_w != req_addr)) begin
                        // Redirected: discard this word; a held-word hit needs no new fetch.
                        if (miss) begin
                            req_addr_n = addr_w;
                            state_n    = D_LO;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (state == D_LO) begin
                        word_lo_n = rom_data;
                        state_n   = D_HI;
                    end else begin
                        hold_addr_n = req_addr;
                        hold_data_n = beat_word;
                        hold_v_n    = 1'b1;
                        if (PREFETCH_EN) begin
                            pf_addr_n = req_addr + FOUR;
                            state_n   = P_LO;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            P_LO, P_HI: begin
                rom_addr = (state == P_LO) ? pf_addr : pf_addr + TWO;
                if (beat_last) begin
                    if (miss && (addr_w != pf_addr)) begin
                        req_addr_n = addr_w;
                        state_n    = D_LO;
                    end else if (state == P_LO) begin
                        word_lo_n = rom_data;
                        state_n   = P_HI;
                    end else if (inst_mem_read_en && (addr_w == pf_addr)) begin
                        // Demand caught up with the prefetch: retire straight to the held buffer.
                        hold_addr_n = pf_addr;
                        hold_data_n = beat_word;
                        hold_v_n    = 1'b1;
                        pf_addr_n   = pf_addr + FOUR;
                        state_n     = P_LO;
                    end else begin
                        pf_data_n = beat_word;
                        pf_v_n    = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            pf_addr   <= '0;
            pf_v      <= 1'b0;
            hold_addr <= '0;
            hold_v    <= 1'b0;
            word_lo   <= '0;
            // NOTE: buffer data is reset as well, because hold_data drives inst_data and that must read 0 out of reset.
            pf_data   <= '0;
            hold_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state     <= state_n;
            req_addr  <= req_addr_n;
            pf_addr   <= pf_addr_n;
            pf_data   <= pf_data_n;
            pf_v      <= pf_v_n;
            hold_addr <= hold_addr_n;
            hold_data <= hold_data_n;
            hold_v    <= hold_v_n;
            word_lo   <= word_lo_n;
            if (state == IDLE || beat_last) cnt <= '0;
            else                            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder: directed fetch scenarios plus randomized
// fetch streams, checked against a ROM model that only returns data after a full beat.
module tb_inst_mem_responder;

    localparam int W        = 2;
    localparam int BEAT     = W + 1;
    localparam int MISS_LAT = 1 + 2 * BEAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mem_read_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_mem_ready;
    logic        rom_rd;
    logic [31:0] rom_addr;
    logic [15:0] rom_data;

    inst_mem_responder #(.XLEN(32), .WAIT_STATES(W), .PREFETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inst_mem_read_en(inst_mem_read_en), .inst_addr(inst_addr),
        .inst_data(inst_data), .inst_mem_ready(inst_mem_ready),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0, n_pass = 0;
    int   cyc = 0, req_cyc = 0, resp_cyc = 0;
    int   sent = 0, resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: two fixed halfwords at 0/2, a hash everywhere else.
    function automatic logic [15:0] rom_fn(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 16'h0013;
        if (a == 32'd2) return 16'h0050;
        h = a * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    // Little-endian word: low halfword from the lower address.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        return {rom_fn(b + 32'd2), rom_fn(b)};
    endfunction

    // Fixed-latency ROM: data is only valid once the address has been held for a whole beat.
    logic        prev_rd = 1'b0;
    logic [31:0] prev_addr = '0;
    int          age_reg = 0, age_now;
    always_comb begin
        age_now  = (rom_rd && prev_rd && rom_addr == prev_addr) ? age_reg + 1 : 1;
        rom_data = (rom_rd && age_now >= BEAT) ? rom_fn(rom_addr) : 16'hBAD0;
    end
    always @(posedge clk) begin
        prev_rd   <= rom_rd;
        prev_addr <= rom_addr;
        age_reg   <= age_now;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && inst_mem_ready) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("resp_data", inst_data, mon_e.data);
                resp_cyc = cyc;
                resp_cnt++;
            end else begin
                check("ready_data", inst_data, ref_word(inst_addr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        inst_addr        = a;
        inst_mem_read_en = 1'b1;
        req_cyc          = cyc;
        sent++;
    endtask

    task automatic wait_resp(input int exp_lat, input string name);
        int n;
        n = 0;
        while (resp_cnt < sent && n < 40) begin
            step(1);
            n++;
        end
        check({name, "_done"}, 32'(resp_cnt), 32'(sent));
        if (resp_cnt < sent) begin
            exp_q.delete();
            resp_cnt = sent;
        end else if (exp_lat >= 0) begin
            check({name, "_lat"}, 32'(resp_cyc - req_cyc), 32'(exp_lat));
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (rom_rd && n < 30) begin
            step(1);
            n++;
        end
        check(name, 32'(rom_rd), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, busy;
        logic [31:0] cur, a;
        rst = 1'b0;
        inst_mem_read_en = 1'b0;
        inst_addr = '0;
        step(2);
        @(negedge clk);
        check("rst_rom_rd", 32'(rom_rd), 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_ready", 32'(inst_mem_ready), 32'd0);
        step(1);
        rst = 1'b1;
        step(1);

        // Miss at 0x0: three cycles on 0x0, three on 0x2, then prefetch of 0x4.
        start_req(32'h0, 32'h0050_0013);
        @(posedge clk);
        for (int i = 0; i < 2 * BEAT; i++) begin
            @(negedge clk);
            check("miss_rom_rd", 32'(rom_rd), 32'd1);
            check("miss_rom_addr", rom_addr, (i < BEAT) ? 32'h0 : 32'h2);
            check("miss_no_ready", 32'(inst_mem_ready), 32'd0);
        end
        wait_resp(MISS_LAT, "miss0");
        @(negedge clk);
        check("pf4_rom_addr", rom_addr, 32'h4);
        check("pf4_rom_rd", 32'(rom_rd), 32'd1);

        // Completed prefetch hit: zero wait, next prefetch starts the following cycle.
        wait_idle("pf4_done");
        start_req(32'h4, ref_word(32'h4));
        wait_resp(0, "pfhit4");
        @(negedge clk);
        check("pf8_rom_addr", rom_addr, 32'h8);
        check("pf8_rom_rd", 32'(rom_rd), 32'd1);

        // Demand catches the in-flight prefetch in its high beat.
        n = 0;
        while (rom_addr != 32'hA && n < 20) begin
            step(1);
            n++;
        end
        check("pf8_hi_reached", rom_addr, 32'hA);
        start_req(32'h8, ref_word(32'h8));
        wait_resp(BEAT, "promote8");
        @(negedge clk);
        check("pfc_rom_addr", rom_addr, 32'hC);
        check("pfc_rom_rd", 32'(rom_rd), 32'd1);

        // Fetch stall: ready and data hold with read_en low; only the pending prefetch runs.
        inst_mem_read_en = 1'b0;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ready", 32'(inst_mem_ready), 32'd1);
            check("stall_data", inst_data, ref_word(32'h8));
            if (rom_rd) busy++;
        end
        check("stall_rom_quiet", 32'(rom_rd), 32'd0);
        check("stall_rom_busy_bound", 32'(busy <= 2 * BEAT), 32'd1);
        step(1);
        start_req(32'hC, ref_word(32'hC));
        wait_resp(0, "pfhitc");

        // Redirect in D_LO: old beat finishes, 0x100 never signalled, fresh 0x200 fetch.
        wait_idle("pf10_done");
        inst_addr = 32'h100;
        inst_mem_read_en = 1'b1;
        step(1);
        start_req(32'h200, ref_word(32'h200));
        for (int i = 0; i < 3 * BEAT; i++) begin
            @(negedge clk);
            check("redir_no_ready", 32'(inst_mem_ready), 32'd0);
            check("redir_rom_addr", rom_addr,
                  (i < BEAT) ? 32'h100 : (i < 2 * BEAT) ? 32'h200 : 32'h202);
        end
        wait_resp(3 * BEAT, "redir200");

        // Reset in the middle of D_HI, then a fetch at the top of memory that wraps its prefetch.
        wait_idle("pf204_done");
        inst_addr = 32'h40;
        inst_mem_read_en = 1'b1;
        n = 0;
        while (!(rom_rd && rom_addr == 32'h42) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("dhi_reached", rom_addr, 32'h42);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rom_rd", 32'(rom_rd), 32'd0);
        check("abort_rom_addr", rom_addr, 32'd0);
        check("abort_ready", 32'(inst_mem_ready), 32'd0);
        check("abort_inst_data", inst_data, 32'd0);
        inst_addr = 32'h200;
        inst_mem_read_en = 1'b0;
        #1;
        check("abort_hold_invalid", 32'(inst_mem_ready), 32'd0);
        step(2);
        rst = 1'b1;
        step(1);
        check("post_rst_hold_invalid", 32'(inst_mem_ready), 32'd0);
        start_req(32'hFFFF_FFFC, ref_word(32'hFFFF_FFFC));
        wait_resp(MISS_LAT, "top_word");
        @(negedge clk);
        check("wrap_pf_rom_rd", 32'(rom_rd), 32'd1);
        check("wrap_pf_rom_addr", rom_addr, 32'h0);
        wait_idle("wrap_pf_done");
        start_req(32'h0, 32'h0050_0013);
        wait_resp(0, "wrap_pfhit");

        // Randomized fetch streams with stalls, re-requests and abandoned requests.
        cur = 32'h0;
        for (int t = 0; t < 150; t++) begin
            n = $urandom_range(0, 99);
            if (n < 45)      a = cur + 32'd4;
            else if (n < 60) a = cur;
            else             a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 15) begin
                inst_addr = 32'($urandom_range(0, 255)) << 2;
                inst_mem_read_en = 1'b1;
                step($urandom_range(1, 8));
            end
            start_req(a, ref_word(a));
            wait_resp(-1, "rand");
            cur = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 20) begin
                inst_mem_read_en = 1'b0;
                step($urandom_range(1, 6));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
